// File: rtl/uns_add_pkg.sv
// Shared sizing helpers for the unary-stream adder: difference register width
// and its saturation limits.
package uns_add_pkg;

    function automatic int diff_w(input int len_w, input int n);
        return len_w + $clog2(n + 1) + 2;
    endfunction

    function automatic int sat_hi(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/uns_add_n_pop_cnt.sv
// Combinational population count over an N-bit vector.
module pop_cnt #(
    parameter int N = 8
) (
    input  logic [N-1:0]           bits_i,
    output logic [$clog2(N+1)-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++)
            cnt_o = cnt_o + ($clog2(N+1))'(bits_i[i]);
    end

endmodule

// File: rtl/uns_add_n.sv
// Non-scaled unary bitstream adder: tracks (ideal ones - emitted ones) in a
// saturating signed register and emits a one whenever that difference is positive.
module uns_add_n
    import uns_add_pkg::*;
#(
    parameter int N        = 8,
    parameter int LEN_W    = 8,
    parameter int OFFSET   = 0,
    parameter int AUTO_CLR = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] in,
    input  logic [N-1:0] neg_mask,
    output logic         out,
    output logic         done
);

    localparam int DW = diff_w(LEN_W, N);
    localparam int CW = $clog2(N + 1);
    localparam logic signed [DW:0] SAT_HI = (DW+1)'(sat_hi(DW));
    localparam logic signed [DW:0] SAT_LO = (DW+1)'(sat_lo(DW));

    logic [CW-1:0]          pos, neg;
    logic signed [DW-1:0]   diff_q, diff_d;
    logic signed [DW:0]     sum_w;
    logic [LEN_W-1:0]       cnt_q;
    logic                   done_q;
    logic                   wrap;

    pop_cnt #(.N(N)) u_pos (.bits_i(in & ~neg_mask), .cnt_o(pos));
    pop_cnt #(.N(N)) u_neg (.bits_i(in &  neg_mask), .cnt_o(neg));

    // One guard bit above DW is enough: a single step moves diff by at most 2N+1.
    always_comb begin
        sum_w = {diff_q[DW-1], diff_q} + (DW+1)'(pos) - (DW+1)'(neg)
              - (DW+1)'(OFFSET) - (DW+1)'(out);
        if (sum_w > SAT_HI)
            diff_d = SAT_HI[DW-1:0];
        else if (sum_w < SAT_LO)
            diff_d = SAT_LO[DW-1:0];
        else
            diff_d = sum_w[DW-1:0];
    end

    assign out  = ~diff_q[DW-1] & (|diff_q);
    assign wrap = &cnt_q;
    assign done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (clr) begin
            diff_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (en) begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= wrap;
            diff_q <= (wrap && AUTO_CLR != 0) ? '0 : diff_d;
        end else begin
            done_q <= 1'b0;
        end
    end

endmodule
